fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches one instruction per cycle from a combinational
// instruction memory into a circular buffer drained by dispatch; commit redirects squash it.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = `MEMI_SIZE_LOG,
    parameter int INST_W = `INST_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_W-1:0]            memi_req_addr,
    input  logic [INST_W-1:0]          memi_resp_data,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INST_W-1:0]          deq_inst,
    output logic                       deq_predicted_taken,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   fetch_pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              pt_mem   [DEPTH];

    logic full;
    logic empty;
    logic enq;
    logic deq;

    // Dequeue handshake: an entry transfers on a posedge where deq_valid && deq_ready;
    // deq_valid never depends on deq_ready, and deq_* hold while valid && !ready.
    always_comb begin
        full          = (count_q == FULL_COUNT);
        empty         = (count_q == '0);
        enq           = !full && !redirect_valid;
        deq_valid     = !empty && !redirect_valid;
        deq           = deq_valid && deq_ready;
        memi_req_addr = fetch_pc;
        count         = count_q;
        deq_pc              = pc_mem[head];
        deq_inst            = inst_mem[head];
        deq_predicted_taken = pt_mem[head];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= '0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                tail     <= tail + PTR_W'(1);
                fetch_pc <= fetch_pc + PC_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Payload is qualified by count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= memi_resp_data;
            pt_mem[tail]   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with DEPTH=4, PC_W=4 and a combinational
// instruction memory whose contents are a fixed function of the address.
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 4;
    localparam int INST_W = 32;

    logic              clk;
    logic              rst;
    logic [PC_W-1:0]   memi_req_addr;
    logic [INST_W-1:0] memi_resp_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              deq_valid;
    logic              deq_ready;
    logic [PC_W-1:0]   deq_pc;
    logic [INST_W-1:0] deq_inst;
    logic              deq_predicted_taken;
    logic [2:0]        count;

    int checks;
    int failures;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .memi_req_addr       (memi_req_addr),
        .memi_resp_data      (memi_resp_data),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .deq_valid           (deq_valid),
        .deq_ready           (deq_ready),
        .deq_pc              (deq_pc),
        .deq_inst            (deq_inst),
        .deq_predicted_taken (deq_predicted_taken),
        .count               (count)
    );

    function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
        return 32'hC0DE_0000 + ({28'd0, pc} * 32'd17);
    endfunction

    assign memi_resp_data = inst_of(memi_req_addr);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (memi_req_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", memi_req_addr); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (count !== 3'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (memi_req_addr !== 4'(i)) begin failures++; $display("FAIL fill_addr i=%0d got=%0d exp=%0d", i, memi_req_addr, i); end
        end
        step();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (memi_req_addr !== 4'd4) begin failures++; $display("FAIL full_addr_hold got=%0d exp=4", memi_req_addr); end
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL full_deq_valid got=%b exp=1", deq_valid); end
        checks++; if (deq_pc !== 4'd0) begin failures++; $display("FAIL full_deq_pc got=%0d exp=0", deq_pc); end
        checks++; if (deq_inst !== inst_of(4'd0)) begin failures++; $display("FAIL full_deq_inst got=%h exp=%h", deq_inst, inst_of(4'd0)); end
        checks++; if (deq_predicted_taken !== 1'b0) begin failures++; $display("FAIL full_pred got=%b exp=0", deq_predicted_taken); end
    endtask

    task automatic test_stall_stable();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (deq_pc !== 4'd0 || deq_inst !== inst_of(4'd0)) begin failures++; $display("FAIL stall_stable got=%0d/%h exp=0/%h", deq_pc, deq_inst, inst_of(4'd0)); end
        end
    endtask

    task automatic test_full_pulse();
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL pulse_count got=%0d exp=3", count); end
        checks++; if (memi_req_addr !== 4'd4) begin failures++; $display("FAIL pulse_no_bypass_addr got=%0d exp=4", memi_req_addr); end
        checks++; if (deq_pc !== 4'd1) begin failures++; $display("FAIL pulse_deq_pc got=%0d exp=1", deq_pc); end
        step();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL refill_count got=%0d exp=4", count); end
        checks++; if (memi_req_addr !== 4'd5) begin failures++; $display("FAIL refill_addr got=%0d exp=5", memi_req_addr); end
        checks++; if (deq_pc !== 4'd1) begin failures++; $display("FAIL refill_deq_pc got=%0d exp=1", deq_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        deq_ready = 1'b1;
        step();
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 4'd0 || count !== 3'd1) begin failures++; $display("FAIL stream_first got=v%b pc%0d c%0d exp=v1 pc0 c1", deq_valid, deq_pc, count); end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++; if (deq_pc !== 4'(k) || deq_inst !== inst_of(4'(k))) begin failures++; $display("FAIL stream_pc k=%0d got=%0d exp=%0d", k, deq_pc, k); end
            checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, count); end
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) step();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 4'd9;
        #1;
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL redir_deq_valid_masked got=%b exp=0", deq_valid); end
        step();
        redirect_valid = 1'b0;
        deq_ready      = 1'b0;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=c%0d v%b exp=c0 v0", count, deq_valid); end
        checks++; if (memi_req_addr !== 4'd9) begin failures++; $display("FAIL redir_addr got=%0d exp=9", memi_req_addr); end
        step();
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 4'd9) begin failures++; $display("FAIL redir_first got=v%b pc%0d exp=v1 pc9", deq_valid, deq_pc); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 4'd14;
        deq_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (deq_valid !== 1'b1 || deq_pc !== 4'((14 + k) % 16)) begin failures++; $display("FAIL wrap_pc k=%0d got=%0d exp=%0d", k, deq_pc, (14 + k) % 16); end
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_redirect_twice();
        redirect_valid = 1'b1;
        redirect_pc    = 4'd3;
        step();
        redirect_pc    = 4'd7;
        step();
        redirect_valid = 1'b0;
        checks++; if (memi_req_addr !== 4'd7 || count !== 3'd0) begin failures++; $display("FAIL b2b_redir got=a%0d c%0d exp=a7 c0", memi_req_addr, count); end
        step();
        checks++; if (deq_pc !== 4'd7 || deq_valid !== 1'b1) begin failures++; $display("FAIL b2b_redir_deq got=pc%0d v%b exp=pc7 v1", deq_pc, deq_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) step();
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || memi_req_addr !== 4'd0) begin failures++; $display("FAIL areset got=c%0d v%b a%0d exp=c0 v0 a0", count, deq_valid, memi_req_addr); end
        do_reset();
        step();
        checks++; if (deq_pc !== 4'd0 || count !== 3'd1) begin failures++; $display("FAIL areset_restart got=pc%0d c%0d exp=pc0 c1", deq_pc, count); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_fill();
        test_stall_stable();
        test_full_pulse();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_redirect_twice();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
